rx_serial_8e1: RTL and testbench
================================

RX_SERIAL_8E1 -- requirements
Module: rx_serial_8e1

Interface
REQ-001 Parameter M, default 434, clock cycles per bit (50 MHz / 115200 baud).
REQ-002 Parameter N, default 9, width of the bit-time counter.
REQ-003 clock  input  1  system clock, all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 dado_serial  input  1  serial line, idle high, 8E1 frames, LSB first.
REQ-006 recebe  input  1  one-cycle consumer acknowledge that clears tem_dado.
REQ-007 dados_ascii  output  8  last received byte.
REQ-008 pronto  output  1  one-cycle pulse at the end of every frame, good or bad.
REQ-009 tem_dado  output  1  valid byte pending; set on an error-free frame.
REQ-010 erro_paridade  output  1  the last frame's parity bit disagreed with even parity.
REQ-011 erro_stop  output  1  the last frame's stop bit sampled low (framing error).
REQ-012 db_estado  output  4  current FSM state code, for debug.

Function
REQ-013 The FSM SHALL use these states: IDLE=0, START=1, DADOS=2, PARIDADE=3, STOP=4, FIM=5.
- IDLE: waits for the line to be armed, then a low sample.
- FIM lasts exactly one cycle, then returns to IDLE.
REQ-014 Arming: IDLE SHALL accept a start only after at least one high sample since reset or since the last FIM.
REQ-015 Start detection: the first armed low sample in IDLE is cycle t0.
- At t0, the bit counter clears and the FSM enters START.
REQ-016 START SHALL wait M/2 (217) cycles, then resample the line.
- Low: enter DADOS.
- High (false start): return to IDLE with no pronto and no flag change.
REQ-017 Sampling times: data bit i (i=0..7) at t0+217+434*(i+1); parity at t0+217+434*9; stop at t0+217+434*10.
REQ-018 Data bits SHALL shift in LSB first into an 8-bit shift register.
REQ-019 At the stop sample the FSM SHALL enter FIM, and on that cycle:
- dados_ascii loads the shift register, even if the frame has errors.
- erro_paridade = XOR of the 8 data bits and the parity bit.
- erro_stop = NOT stop sample.
- pronto = 1.
REQ-020 Latency: pronto SHALL be high exactly at cycle t0+217+434*10+1 = t0+4558.
REQ-021 tem_dado SHALL set in FIM only when both error flags are 0, and clear on a recebe=1 cycle.
- If set and clear occur in the same cycle, set wins.
REQ-022 A new error-free frame while tem_dado=1 SHALL overwrite dados_ascii; tem_dado stays 1.
REQ-023 Error flags SHALL hold their values until the next FIM.
REQ-024 recebe SHALL have no effect on the FSM or on dados_ascii.
REQ-025 The bit-time counter SHALL wrap from M-1 to 0 and restart at each start detection.

Reset
REQ-026 While reset=1, asynchronously:
- FSM = IDLE and disarmed.
- dados_ascii = 0x00.
- pronto, tem_dado, erro_paridade, erro_stop = 0.
- db_estado = 0.
- Counters and shift register = 0.
REQ-027 Reset mid-frame SHALL abort the frame with no pronto.
- If the line is still low at release, reception waits for a high sample first (REQ-014).

Configuration
REQ-028 Macro RX_SERIAL_SYNC_EN:
- Defined: dado_serial passes through a two-flop synchronizer (reset value 1) before all logic; every timing in REQ-015..REQ-020 shifts by +2 cycles relative to the pin.
- Undefined: dado_serial is used directly.

Verification
REQ-029 Send 0x41, parity 0, stop 1 -> pronto at t0+4558; dados_ascii=0x41; tem_dado=1; both errors 0.
REQ-030 Send 0x07 with parity 0 -> erro_paridade=1; dados_ascii=0x07; tem_dado stays 0; pronto pulses.
REQ-031 Send 0x55, parity 0, stop 0 -> erro_stop=1; erro_paridade=0; tem_dado=0.
REQ-032 Low glitch of 100 cycles on an idle line -> FSM back to IDLE by t0+218; no pronto; all outputs unchanged.
REQ-033 Reset during bit 4 with the line held low 500 more cycles, then send 0xA5 -> no pronto from the aborted frame; 0xA5 received with tem_dado=1.
REQ-034 recebe=1 on the FIM cycle of a good frame -> tem_dado=1 on the next cycle; a later recebe pulse clears it.

Source files
------------

// File: rtl/rx_serial_8e1.sv
// rx_serial_8e1: 8E1 UART receiver with even-parity and framing checks.
// Define RX_SERIAL_SYNC_EN to pass dado_serial through a two-flop synchronizer (+2 cycles latency).
module rx_serial_8e1 #(
    parameter int M = 434,
    parameter int N = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    input  logic       recebe,
    output logic [7:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic [3:0] db_estado
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        STOP     = 4'd4,
        FIM      = 4'd5
    } state_t;

    state_t st_q, st_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sr_q, sr_d, dados_q, dados_d;
    logic par_q, par_d, armed_q, armed_d, pronto_q, pronto_d;
    logic tem_q, tem_d, ep_q, ep_d, es_q, es_d;
    logic rx, wrap, half;

`ifdef RX_SERIAL_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clock or posedge reset)
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], dado_serial};
    assign rx = sync_q[1];
`else
    assign rx = dado_serial;
`endif

    assign wrap = cnt_q == N'(M - 1);
    assign half = cnt_q == N'(M / 2 - 1);

    always_comb begin
        st_d     = st_q;
        cnt_d    = wrap ? '0 : cnt_q + N'(1);
        bit_d    = bit_q;
        sr_d     = sr_q;
        par_d    = par_q;
        dados_d  = dados_q;
        ep_d     = ep_q;
        es_d     = es_q;
        pronto_d = 1'b0;
        armed_d  = armed_q | rx;
        tem_d    = tem_q & ~recebe;
        case (st_q)
            IDLE: if (armed_q && !rx) begin
                st_d  = START;
                cnt_d = '0;
                bit_d = '0;
            end
            START: if (half) begin
                st_d  = rx ? IDLE : DADOS;
                cnt_d = '0;
            end
            DADOS: if (wrap) begin
                sr_d  = {rx, sr_q[7:1]};
                bit_d = bit_q + 3'd1;
                st_d  = (bit_q == 3'd7) ? PARIDADE : DADOS;
            end
            PARIDADE: if (wrap) begin
                par_d = rx;
                st_d  = STOP;
            end
            STOP: if (wrap) begin
                st_d     = FIM;
                dados_d  = sr_q;
                ep_d     = ^{sr_q, par_q};
                es_d     = ~rx;
                pronto_d = 1'b1;
                tem_d    = tem_d | (~^{sr_q, par_q} & rx);
            end
            // a good frame keeps tem_dado set through FIM so a recebe there cannot clear it
            FIM: begin
                st_d    = IDLE;
                armed_d = 1'b0;
                tem_d   = tem_d | ~(ep_q | es_q);
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            st_q     <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            par_q    <= 1'b0;
            dados_q  <= '0;
            armed_q  <= 1'b0;
            pronto_q <= 1'b0;
            tem_q    <= 1'b0;
            ep_q     <= 1'b0;
            es_q     <= 1'b0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            par_q    <= par_d;
            dados_q  <= dados_d;
            armed_q  <= armed_d;
            pronto_q <= pronto_d;
            tem_q    <= tem_d;
            ep_q     <= ep_d;
            es_q     <= es_d;
        end

    assign dados_ascii   = dados_q;
    assign pronto        = pronto_q;
    assign tem_dado      = tem_q;
    assign erro_paridade = ep_q;
    assign erro_stop     = es_q;
    assign db_estado     = st_q;
endmodule

// File: tb/tb_rx_serial_8e1.sv
// tb_rx_serial_8e1: random and directed 8E1 frames checked against a frame-level reference model.
module tb_rx_serial_8e1;
    localparam int M = 434;
    localparam int LAT = 217 + M * 10;
    logic clock = 1'b0, reset = 1'b1, dado_serial = 1'b1, recebe = 1'b0;
    logic [7:0] dados_ascii;
    logic pronto, tem_dado, erro_paridade, erro_stop;
    logic [3:0] db_estado;
    int checks = 0, errors = 0, cyc = 0, np = 0;
    logic [7:0] e_d = 8'h00;
    logic e_ep = 1'b0, e_es = 1'b0, e_tem = 1'b0;

    always #5 clock = ~clock;

    rx_serial_8e1 #(.M(M), .N(9)) dut (
        .clock(clock), .reset(reset), .dado_serial(dado_serial), .recebe(recebe),
        .dados_ascii(dados_ascii), .pronto(pronto), .tem_dado(tem_dado),
        .erro_paridade(erro_paridade), .erro_stop(erro_stop), .db_estado(db_estado)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (pronto) np++;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".dados"}, {24'd0, dados_ascii}, {24'd0, e_d});
        check({tag, ".erro_par"}, {31'd0, erro_paridade}, {31'd0, e_ep});
        check({tag, ".erro_stop"}, {31'd0, erro_stop}, {31'd0, e_es});
        check({tag, ".tem_dado"}, {31'd0, tem_dado}, {31'd0, e_tem});
    endtask

    // one full frame driven from the pin; rm pulses recebe mid-frame, rf pulses it in the FIM cycle
    task automatic send(input string tag, input logic [7:0] b, input logic p, input logic s,
                        input bit rm, input bit rf);
        logic [10:0] fr;
        int t0, np0;
        logic ok;
        fr  = {s, p, b, 1'b0};
        t0  = cyc + 1;
        np0 = np;
        ok  = ((^b) == p) && s;
        for (int i = 0; i < 11; i++)
            for (int j = 0; j < M; j++) begin
                dado_serial = fr[i];
                recebe = (rm && i == 4 && j == 0) || (rf && cyc == t0 + LAT);
                tick();
                if (cyc == t0 + LAT - 1) check({tag, ".pronto_early"}, {31'd0, pronto}, 32'd0);
                if (cyc == t0 + LAT) begin
                    check({tag, ".pronto"}, {31'd0, pronto}, 32'd1);
                    e_d   = b;
                    e_ep  = (^b) ^ p;
                    e_es  = ~s;
                    e_tem = ok | (e_tem & ~rm);
                    check_outs(tag);
                    e_tem = ok | (e_tem & ~rf);
                end
                if (cyc == t0 + LAT + 1) begin
                    check({tag, ".pronto_late"}, {31'd0, pronto}, 32'd0);
                    check({tag, ".tem_after_fim"}, {31'd0, tem_dado}, {31'd0, e_tem});
                end
            end
        recebe = 1'b0;
        dado_serial = 1'b1;
        repeat ($urandom_range(3, 20)) tick();
        check({tag, ".pulses"}, np - np0, 32'd1);
        check_outs({tag, ".idle"});
    endtask

    initial begin
        logic [7:0] b;
        logic [10:0] fr;
        int t0, np0;
        repeat (3) tick();
        check("rst.db_estado", {28'd0, db_estado}, 32'd0);
        check("rst.pronto", {31'd0, pronto}, 32'd0);
        check_outs("rst");
        reset = 1'b0;
        repeat (5) tick();
        send("f41", 8'h41, 1'b0, 1'b1, 1'b0, 1'b0);
        recebe = 1'b1;
        tick();
        recebe = 1'b0;
        e_tem = 1'b0;
        check("ack.tem_dado", {31'd0, tem_dado}, 32'd0);
        send("f07", 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        send("f55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        send("fim_ack", 8'h41, 1'b0, 1'b1, 1'b0, 1'b1);
        recebe = 1'b1;
        tick();
        recebe = 1'b0;
        e_tem = 1'b0;
        check("late_ack.tem_dado", {31'd0, tem_dado}, 32'd0);
        // short low glitch must be rejected at the mid-start resample
        t0 = cyc + 1;
        np0 = np;
        dado_serial = 1'b0;
        repeat (100) tick();
        check("glitch.in_start", {28'd0, db_estado}, 32'd1);
        dado_serial = 1'b1;
        while (cyc < t0 + 218) tick();
        check("glitch.idle", {28'd0, db_estado}, 32'd0);
        check("glitch.pulses", np - np0, 32'd0);
        check_outs("glitch");
        repeat (5) tick();
        // abort during data bit 4 with reset, then hold the line low
        fr = {1'b1, 1'b0, 8'h3C, 1'b0};
        np0 = np;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < ((i == 5) ? M / 2 : M); j++) begin
                dado_serial = fr[i];
                tick();
            end
        dado_serial = 1'b0;
        #2 reset = 1'b1;
        #1;
        e_d = 8'h00; e_ep = 1'b0; e_es = 1'b0; e_tem = 1'b0;
        check("abort.db_estado", {28'd0, db_estado}, 32'd0);
        check_outs("abort");
        tick();
        reset = 1'b0;
        repeat (500) tick();
        check("abort.still_idle", {28'd0, db_estado}, 32'd0);
        check("abort.pulses", np - np0, 32'd0);
        dado_serial = 1'b1;
        repeat (5) tick();
        send("fA5", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            send($sformatf("rnd%0d", k), b,
                 ($urandom_range(0, 3) == 0) ? ~(^b) : ^b,
                 $urandom_range(0, 5) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
